// File: rtl/lcd_rgb_rx_capture.sv
// Parallel RGB LCD receive/capture: pixel coordinates, geometry measurement, lock FSM.
// Optional frame CRC-16-CCITT over captured pixels when LCD_RX_CRC_EN is defined.
module lcd_rgb_rx_capture #(
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2,
    parameter int CW          = 13
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          HS,
    input  logic          VS,
    input  logic          DE,
    input  logic [7:0]    LCDR,
    input  logic [7:0]    LCDG,
    input  logic [7:0]    LCDB,
    output logic          pix_valid,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [23:0]   pix_rgb,
    output logic          frame_start,
    output logic          locked,
    output logic [CW-1:0] meas_htotal,
    output logic [CW-1:0] meas_hact,
    output logic [CW-1:0] meas_vact,
    output logic          err_line,
    output logic          err_geom,
    output logic [15:0]   frame_crc,
    output logic          crc_valid
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [CW-1:0] HACT = CW'(H_ACTIVE);
    localparam logic [CW-1:0] VACT = CW'(V_ACTIVE);
    localparam logic [3:0]    LOCKN = 4'(LOCK_FRAMES);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    logic          hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q;
    logic [23:0]   rgb1_q;
    logic [CW-1:0] hlen_q, xcnt_q, line_q, htot_q, hact_q, vact_q;
    logic [CW-1:0] pix_x_q, pix_y_q;
    logic [23:0]   pix_rgb_q;
    logic          cut_q, bad_q, pix_valid_q, fs_q, el_q, eg_q;
    state_e        state_q, state_d;
    logic [3:0]    match_q, match_d;

    logic          hs_fall, vs_fall, de_rise, de_fall;
    logic          run_done, run_bad, bad_now, match, geom_err;
    logic [CW-1:0] x_pix, y_pix, line_now, hact_now;
    logic          is_locked, pix_valid_d, err_line_d;

    assign hs_fall = hs2_q & ~hs1_q;
    assign vs_fall = vs2_q & ~vs1_q;
    assign de_rise = de1_q & ~de2_q;
    assign de_fall = ~de1_q & de2_q;

    // A run already cut by VS fall does not count as a line
    assign run_done = de_fall & ~cut_q;
    assign run_bad  = run_done & (xcnt_q != HACT);
    assign bad_now  = bad_q | run_bad;
    assign line_now = run_done ? sat_inc(line_q) : line_q;
    assign hact_now = run_done ? xcnt_q : hact_q;
    assign match    = ~bad_now & (hact_now == HACT) & (line_now == VACT);
    assign x_pix    = (de_rise | vs_fall) ? '0 : xcnt_q;
    assign y_pix    = vs_fall ? '0 : line_q;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            hs1_q <= 1'b0; vs1_q <= 1'b0; de1_q <= 1'b0;
            hs2_q <= 1'b0; vs2_q <= 1'b0; de2_q <= 1'b0;
            rgb1_q <= '0;
            hlen_q <= '0; xcnt_q <= '0; line_q <= '0;
            htot_q <= '0; hact_q <= '0; vact_q <= '0;
            cut_q <= 1'b0; bad_q <= 1'b0;
            pix_valid_q <= 1'b0; pix_x_q <= '0; pix_y_q <= '0; pix_rgb_q <= '0;
            fs_q <= 1'b0; el_q <= 1'b0; eg_q <= 1'b0;
        end else begin
            hs1_q <= HS; vs1_q <= VS; de1_q <= DE;
            rgb1_q <= {LCDR, LCDG, LCDB};
            hs2_q <= hs1_q; vs2_q <= vs1_q; de2_q <= de1_q;
            hlen_q <= hs_fall ? CW'(1) : sat_inc(hlen_q);
            if (hs_fall) htot_q <= hlen_q;
            if (de1_q) xcnt_q <= sat_inc(x_pix);
            if (run_done) hact_q <= xcnt_q;
            line_q <= vs_fall ? '0 : line_now;
            if (vs_fall) vact_q <= line_now;
            bad_q <= vs_fall ? 1'b0 : bad_now;
            if (vs_fall && de1_q && !de_rise) cut_q <= 1'b1;
            else if (de_rise) cut_q <= 1'b0;
            pix_valid_q <= pix_valid_d;
            if (de1_q) begin
                pix_x_q   <= x_pix;
                pix_y_q   <= y_pix;
                pix_rgb_q <= rgb1_q;
            end
            fs_q <= vs_fall;
            el_q <= err_line_d;
            eg_q <= geom_err;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEARCH;
            match_q <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        geom_err = 1'b0;
        unique case (state_q)
            SEARCH: if (vs_fall) begin
                state_d = MEASURE;
                match_d = '0;
            end
            MEASURE: if (vs_fall) begin
                if (match) begin
                    match_d = match_q + 4'd1;
                    if (match_q + 4'd1 == LOCKN) state_d = LOCKED;
                end else begin
                    match_d  = '0;
                    geom_err = 1'b1;
                end
            end
            LOCKED: if (vs_fall && !match) begin
                state_d  = MEASURE;
                match_d  = '0;
                geom_err = 1'b1;
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        is_locked   = (state_q == LOCKED);
        pix_valid_d = de1_q & is_locked;
        err_line_d  = run_bad & is_locked;
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = fs_q;
    assign locked      = is_locked;
    assign meas_htotal = htot_q;
    assign meas_hact   = hact_q;
    assign meas_vact   = vact_q;
    assign err_line    = el_q;
    assign err_geom    = eg_q;

`ifdef LCD_RX_CRC_EN
    function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 23; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    logic [15:0] crc_q, crc_next, fcrc_q;
    logic        cv_q;

    assign crc_next = pix_valid_d ? crc_px(crc_q, rgb1_q) : crc_q;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            crc_q  <= 16'hFFFF;
            fcrc_q <= '0;
            cv_q   <= 1'b0;
        end else if (vs_fall) begin
            crc_q  <= 16'hFFFF;
            fcrc_q <= crc_next;
            cv_q   <= is_locked;
        end else begin
            crc_q <= crc_next;
            cv_q  <= 1'b0;
        end
    end

    assign frame_crc = fcrc_q;
    assign crc_valid = cv_q;
`else
    assign frame_crc = 16'h0000;
    assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_rgb_rx_capture.sv
// Scaled-geometry bench for lcd_rgb_rx_capture: 16x6 active, htotal 28, vtotal 10.
// Pixel scoreboard plus per-scenario tasks for lock, errors, CRC, reset and saturation.
module tb_lcd_rgb_rx_capture;

    localparam int HA = 16, VA = 6, LF = 2, CW = 13;
    localparam int HT = 28, HSW = 4, DES = 8;
    localparam int VT = 10, VSW = 2, VST = 3;
    localparam int SAT = (1 << CW) - 1;

    logic          CLK = 1'b0, rst_n = 1'b0;
    logic          HS = 1'b0, VS = 1'b0, DE = 1'b0;
    logic [7:0]    LCDR = '0, LCDG = '0, LCDB = '0;
    logic          pix_valid, frame_start, locked, err_line, err_geom, crc_valid;
    logic [CW-1:0] pix_x, pix_y, meas_htotal, meas_hact, meas_vact;
    logic [23:0]   pix_rgb;
    logic [15:0]   frame_crc;

    lcd_rgb_rx_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF), .CW(CW)) dut (
        .CLK(CLK), .rst_n(rst_n), .HS(HS), .VS(VS), .DE(DE),
        .LCDR(LCDR), .LCDG(LCDG), .LCDB(LCDB),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked),
        .meas_htotal(meas_htotal), .meas_hact(meas_hact), .meas_vact(meas_vact),
        .err_line(err_line), .err_geom(err_geom),
        .frame_crc(frame_crc), .crc_valid(crc_valid)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        int          x;
        int          y;
        logic [23:0] rgb;
    } px_t;

    px_t sb[$];
    int  cyc = 0;
    int  vectors = 0, miscompares = 0;
    int  fs_cnt = 0, el_cnt = 0, eg_cnt = 0, cv_cnt = 0, pix_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (rst_n) begin
            if (frame_start) fs_cnt++;
            if (err_line) el_cnt++;
            if (err_geom) eg_cnt++;
            if (crc_valid) cv_cnt++;
            if (pix_valid) begin
                px_t e;
                pix_cnt++;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL pix_unexpected: got x=%0d y=%0d rgb=%h at cyc %0d, none expected",
                             pix_x, pix_y, pix_rgb, cyc);
                end else begin
                    e = sb.pop_front();
                    if (cyc != e.cyc + 2 || pix_x !== CW'(e.x) || pix_y !== CW'(e.y) || pix_rgb !== e.rgb) begin
                        miscompares++;
                        $display("FAIL pix: got cyc=%0d x=%0d y=%0d rgb=%h, want cyc=%0d x=%0d y=%0d rgb=%h",
                                 cyc, pix_x, pix_y, pix_rgb, e.cyc + 2, e.x, e.y, e.rgb);
                    end
                end
            end
        end
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic idle(input int n);
        HS = 1'b1; VS = 1'b1; DE = 1'b0;
        tick(n);
    endtask

    // One frame; line a==bad_line gets bad_len pixels, only nact active lines, stops after stop_line lines
    task automatic send_frame(input bit expv, input int nact, input int bad_line, input int bad_len,
                              input bit rnd, input logic [23:0] rgbc, input int stop_line);
        int a, len;
        logic d;
        logic [23:0] c;
        for (int l = 0; l < VT && l < stop_line; l++) begin
            for (int h = 0; h < HT; h++) begin
                a   = l - VST;
                len = (a == bad_line) ? bad_len : HA;
                d   = (a >= 0 && a < nact && h >= DES && h < DES + len);
                c   = rnd ? 24'($urandom) : rgbc;
                HS  = (h >= HSW);
                VS  = (l >= VSW);
                DE  = d;
                {LCDR, LCDG, LCDB} = c;
                if (d && expv) sb.push_back('{cyc, h - DES, a, c});
                tick(1);
            end
        end
    endtask

    task automatic check_sb_empty(input string tag);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s sb_pending: got %0d pixels missing, want 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        vectors++;
        if ({pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, meas_htotal, meas_hact,
             meas_vact, err_line, err_geom, frame_crc, crc_valid} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got locked=%b pix_valid=%b htot=%0d crc=%h, want all 0",
                     locked, pix_valid, meas_htotal, frame_crc);
        end
        rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_lock();
        send_frame(0, VA, -1, 0, 1, 24'h0, VT);
        send_frame(0, VA, -1, 0, 1, 24'h0, VT);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_early: got locked=%b after 2 VS falls, want 0", locked);
        end
        send_frame(1, VA, -1, 0, 1, 24'h0, VT);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL lock: got locked=%b after 3 VS falls, want 1", locked);
        end
        vectors++;
        if (meas_htotal !== CW'(HT) || meas_hact !== CW'(HA) || meas_vact !== CW'(VA)) begin
            miscompares++;
            $display("FAIL meas: got htot=%0d hact=%0d vact=%0d, want %0d %0d %0d",
                     meas_htotal, meas_hact, meas_vact, HT, HA, VA);
        end
        vectors++;
        if (fs_cnt != 3 || el_cnt != 0 || eg_cnt != 0) begin
            miscompares++;
            $display("FAIL lock_pulses: got fs=%0d el=%0d eg=%0d, want 3 0 0", fs_cnt, el_cnt, eg_cnt);
        end
        check_sb_empty("lock");
    endtask

    task automatic test_err_line();
        int el0, eg0;
        el0 = el_cnt; eg0 = eg_cnt;
        send_frame(1, VA, 2, HA - 1, 1, 24'h0, VT);
        vectors++;
        if (el_cnt - el0 != 1 || eg_cnt != eg0 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL err_line: got el=%0d eg=%0d locked=%b, want 1 0 1",
                     el_cnt - el0, eg_cnt - eg0, locked);
        end
        send_frame(0, VA, -1, 0, 1, 24'h0, VT);
        vectors++;
        if (eg_cnt - eg0 != 1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL err_geom: got eg=%0d locked=%b, want 1 0", eg_cnt - eg0, locked);
        end
        send_frame(0, VA, -1, 0, 1, 24'h0, VT);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL relock_early: got locked=%b, want 0", locked);
        end
        check_sb_empty("err_line");
    endtask

    task automatic test_pixels();
        int p0, el0;
        p0 = pix_cnt; el0 = el_cnt;
        send_frame(1, VA, -1, 0, 0, 24'hFF0000, VT);
        vectors++;
        if (locked !== 1'b1 || pix_cnt - p0 != HA * VA || el_cnt != el0) begin
            miscompares++;
            $display("FAIL pixels: got locked=%b pix=%0d el=%0d, want 1 %0d 0",
                     locked, pix_cnt - p0, el_cnt - el0, HA * VA);
        end
        check_sb_empty("pixels");
    endtask

`ifdef LCD_RX_CRC_EN
    function automatic logic [15:0] gold_crc(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 23; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else r = {r[14:0], 1'b0};
        end
        return r;
    endfunction
`endif

    task automatic test_crc();
        int cv0, el0;
        cv0 = cv_cnt; el0 = el_cnt;
        send_frame(1, 1, 0, 1, 0, 24'h000000, VT);
        send_frame(0, VA, -1, 0, 1, 24'h0, VT);
        vectors++;
        if (el_cnt - el0 != 1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL crc_frame: got el=%0d locked=%b, want 1 0", el_cnt - el0, locked);
        end
`ifdef LCD_RX_CRC_EN
        vectors++;
        if (cv_cnt - cv0 != 1 || frame_crc !== gold_crc(16'hFFFF, 24'h000000)) begin
            miscompares++;
            $display("FAIL crc: got pulses=%0d crc=%h, want 1 %h",
                     cv_cnt - cv0, frame_crc, gold_crc(16'hFFFF, 24'h000000));
        end
`else
        vectors++;
        if (cv_cnt != 0 || frame_crc !== 16'h0000) begin
            miscompares++;
            $display("FAIL crc_off: got pulses=%0d crc=%h, want 0 0000", cv_cnt, frame_crc);
        end
`endif
        send_frame(0, VA, -1, 0, 1, 24'h0, VT);
        check_sb_empty("crc");
    endtask

    task automatic test_reset_mid();
        send_frame(1, VA, -1, 0, 1, 24'h0, VST + 2);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_lock: got locked=%b, want 1", locked);
        end
        check_sb_empty("reset_mid");
        rst_n = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, meas_htotal, meas_hact,
             meas_vact, err_line, err_geom, frame_crc, crc_valid} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got locked=%b htot=%0d hact=%0d vact=%0d, want all 0",
                     locked, meas_htotal, meas_hact, meas_vact);
        end
        tick(3);
        rst_n = 1'b1;
        idle(5);
        send_frame(0, VA, -1, 0, 1, 24'h0, VT);
        send_frame(0, VA, -1, 0, 1, 24'h0, VT);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL relock_reset_early: got locked=%b, want 0", locked);
        end
        send_frame(1, VA, -1, 0, 1, 24'h0, VT);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL relock_reset: got locked=%b, want 1", locked);
        end
        check_sb_empty("reset_relock");
    endtask

    task automatic test_saturation();
        int el0;
        logic [23:0] c;
        el0 = el_cnt;
        HS = 1'b1; VS = 1'b1;
        for (int i = 0; i < 9000; i++) begin
            c  = 24'($urandom);
            DE = 1'b1;
            {LCDR, LCDG, LCDB} = c;
            sb.push_back('{cyc, (i > SAT) ? SAT : i, VA, c});
            tick(1);
        end
        idle(6);
        vectors++;
        if (meas_hact !== CW'(SAT) || el_cnt - el0 != 1 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL saturation: got hact=%0d el=%0d locked=%b, want %0d 1 1",
                     meas_hact, el_cnt - el0, locked, SAT);
        end
        check_sb_empty("saturation");
    endtask

    initial begin
        test_reset();
        test_lock();
        test_err_line();
        test_pixels();
        test_crc();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
